// File: rtl/obj_build_sequencer.sv
// Converts a typed key/value entry stream into the stack-engine command sequence
// NEWOBJ, then {PUSH_<kind>, SETPROP(-2,key)} per entry. Optional macro: ERR_SKIP_EN.
module obj_build_sequencer #(
    parameter int KEY_W  = 8,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              abort,
    input  logic              start,
    input  logic              empty,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_kind,
    input  logic [KEY_W-1:0]  in_key,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [2:0]        cmd_op,
    output logic [DATA_W-1:0] cmd_arg,
    output logic [KEY_W-1:0]  cmd_key,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [CNT_W-1:0]  entry_count,
    output logic [CNT_W-1:0]  skip_count
);

    localparam logic [2:0] OP_NEWOBJ  = 3'd0;
    localparam logic [2:0] OP_SETPROP = 3'd5;
    localparam logic [DATA_W-1:0] SETPROP_ARG = {{(DATA_W-1){1'b1}}, 1'b0};

    typedef enum logic [2:0] {
        S_IDLE,
        S_NEWOBJ,
        S_FETCH,
        S_PUSH,
        S_SETPROP,
        S_DONE,
        S_ERROR
    } state_t;

    typedef struct packed {
        logic [KEY_W-1:0] key;
        logic             last;
    } entry_t;

    state_t state;
    entry_t ent_q;
    logic   empty_q;

    // PUSH_STR..PUSH_NULL are numbered one above their input kind.
    function automatic logic [2:0] push_op(input logic [2:0] kind);
        return {1'b0, kind[1:0]} + 3'd1;
    endfunction

    function automatic logic [DATA_W-1:0] push_arg(input logic [2:0] kind,
                                                   input logic [DATA_W-1:0] data);
        logic [DATA_W-1:0] arg;
        arg = '0;
        case (kind[1:0])
            2'd0, 2'd1: arg = data;
            2'd2:       arg = {{(DATA_W-1){1'b0}}, data[0]};
            default:    arg = '0;
        endcase
        return arg;
    endfunction

`ifdef ERR_SKIP_EN
    logic [CNT_W-1:0] skip_q;
    assign skip_count = skip_q;
`else
    assign skip_count = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            ent_q       <= '0;
            empty_q     <= 1'b0;
            in_ready    <= 1'b0;
            cmd_valid   <= 1'b0;
            cmd_op      <= '0;
            cmd_arg     <= '0;
            cmd_key     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            entry_count <= '0;
`ifdef ERR_SKIP_EN
            skip_q      <= '0;
`endif
        end else if (abort) begin
            // Counters are kept so software can see how far the object got.
            state     <= S_IDLE;
            ent_q     <= '0;
            empty_q   <= 1'b0;
            in_ready  <= 1'b0;
            cmd_valid <= 1'b0;
            cmd_op    <= '0;
            cmd_arg   <= '0;
            cmd_key   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state       <= S_NEWOBJ;
                        empty_q     <= empty;
                        busy        <= 1'b1;
                        cmd_valid   <= 1'b1;
                        cmd_op      <= OP_NEWOBJ;
                        cmd_arg     <= '0;
                        cmd_key     <= '0;
                        entry_count <= '0;
`ifdef ERR_SKIP_EN
                        skip_q      <= '0;
`endif
                    end
                end

                S_NEWOBJ: begin
                    if (cmd_ready) begin
                        cmd_valid <= 1'b0;
                        if (empty_q) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state    <= S_FETCH;
                            in_ready <= 1'b1;
                        end
                    end
                end

                S_FETCH: begin
                    if (in_valid) begin
                        ent_q.key  <= in_key;
                        ent_q.last <= in_last;
                        if (!in_kind[2]) begin
                            state     <= S_PUSH;
                            in_ready  <= 1'b0;
                            cmd_valid <= 1'b1;
                            cmd_op    <= push_op(in_kind);
                            cmd_arg   <= push_arg(in_kind, in_data);
                            cmd_key   <= '0;
                        end else begin
`ifdef ERR_SKIP_EN
                            // Skipped entry: consumed here, no command issued.
                            if (skip_q != '1)
                                skip_q <= skip_q + 1'b1;
                            if (in_last) begin
                                state    <= S_DONE;
                                in_ready <= 1'b0;
                                done     <= 1'b1;
                            end
`else
                            state    <= S_ERROR;
                            in_ready <= 1'b0;
                            error    <= 1'b1;
`endif
                        end
                    end
                end

                S_PUSH: begin
                    if (cmd_ready) begin
                        state   <= S_SETPROP;
                        cmd_op  <= OP_SETPROP;
                        cmd_arg <= SETPROP_ARG;
                        cmd_key <= ent_q.key;
                    end
                end

                S_SETPROP: begin
                    if (cmd_ready) begin
                        cmd_valid <= 1'b0;
                        cmd_op    <= '0;
                        cmd_arg   <= '0;
                        cmd_key   <= '0;
                        if (entry_count != '1)
                            entry_count <= entry_count + 1'b1;
                        if (ent_q.last) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state    <= S_FETCH;
                            in_ready <= 1'b1;
                        end
                    end
                end

                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end

                // Sticky until abort or rst.
                S_ERROR: begin
                    state <= S_ERROR;
                end

                default: begin
                    state    <= S_IDLE;
                    busy     <= 1'b0;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule
